dnn_train_sequencer: RTL and testbench

//  Top-level run controller for the DRP sparse DNN. It holds the network in reset, then releases it.
//  It then streams N_SAMPLES x N_EPOCHS training samples from an external sample RAM into a_in/y_in,
//  one sample per cycle block. Its cycle counter mirrors the network's internal cycle_block_counter.
//  It drains the pipeline and counts mismatches between a_out and y_out.

---
 rtl/dnn_pkg.sv | 22 ++
 rtl/dnn_err_counter.sv | 44 ++++
 rtl/dnn_train_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_dnn_train_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared types and width helpers for the DNN training run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NETRST,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int ERR_W = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Index width for a value range of n; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dnn_err_counter.sv
// Mismatch counter: popcount of a^b accumulated into a saturating 16-bit total.
// Latency: count reflects an enabled compare one clock later.
// Backpressure: none; en samples every clock, clr wins over en.
// Ports: clk, reset (async active-low), clr, en, a/b (ZO bits), count (16 bits).
module dnn_err_counter
    import dnn_pkg::*;
#(
    parameter int ZO = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [ZO-1:0]    a,
    input  logic [ZO-1:0]    b,
    output logic [ERR_W-1:0] count
);

    localparam int PW = $clog2(ZO + 1);

    logic [PW-1:0]  pc;
    logic [ERR_W:0] sum;

    always_comb begin
        pc = '0;
        for (int i = 0; i < ZO; i++) begin
            pc = pc + PW'(a[i] ^ b[i]);
        end
    end

    // One extra bit catches the carry that signals saturation.
    assign sum = {1'b0, count} + (ERR_W + 1)'(pc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= sum[ERR_W] ? ERR_MAX : sum[ERR_W-1:0];
        end
    end

endmodule

// File: rtl/dnn_train_sequencer.sv
// Run controller: resets the DNN, streams N_SAMPLES x N_EPOCHS samples from RAM, drains, counts output mismatches.
// Latency: first read in the last NETRST clock; done pulses (N_SAMPLES*N_EPOCHS+LAT_BLK)*CPC clocks after RUN entry.
// Backpressure: none; free-running block schedule, abort returns to IDLE next clock, start ignored unless IDLE.
// Ports: clk, reset (async active-low), start, abort in; dnn_reset, mem_rd_en, mem_addr out;
//        a_out/y_out (ZO bits) in; busy, done, epoch_idx, err_count out.
module dnn_train_sequencer
    import dnn_pkg::*;
#(
    parameter  int CPC       = 6,
    parameter  int BEATS     = 4,
    parameter  int OUT_BEATS = 4,
    parameter  int ZO        = 1,
    parameter  int N_SAMPLES = 256,
    parameter  int N_EPOCHS  = 1,
    parameter  int LAT_BLK   = 3,
    parameter  int RST_CLKS  = 2,
    localparam int SW        = idx_w(N_SAMPLES),
    localparam int BW        = idx_w(BEATS),
    localparam int AW        = SW + BW,
    localparam int EW        = idx_w(N_EPOCHS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             dnn_reset,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [ZO-1:0]    a_out,
    input  logic [ZO-1:0]    y_out,
    output logic             busy,
    output logic             done,
    output logic [EW-1:0]    epoch_idx,
    output logic [ERR_W-1:0] err_count
);

    // cnt is sized for CPC+1 so OUT_BEATS == CPC still fits as a compare bound.
    localparam int CW = idx_w(CPC + 1);
    localparam int RW = idx_w(RST_CLKS);
    localparam int LW = idx_w(LAT_BLK + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(CPC - 1);
    localparam logic [CW-1:0] CNT_BEATS  = CW'(BEATS);
    localparam logic [CW-1:0] CNT_OBEATS = CW'(OUT_BEATS);
    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CLKS - 1);
    localparam logic [LW-1:0] LAT_FULL   = LW'(LAT_BLK);
    localparam logic [LW-1:0] LAT_LAST   = LW'(LAT_BLK - 1);
    localparam logic [SW-1:0] SMP_LAST   = SW'(N_SAMPLES - 1);
    localparam logic [EW-1:0] EP_LAST    = EW'(N_EPOCHS - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rst_cnt;
    logic [LW-1:0] warm_blk;   // completed blocks since RUN entry, saturating at LAT_BLK
    logic [LW-1:0] drain_blk;
    logic [SW-1:0] sample_idx;

    logic          cnt_wrap;
    logic [CW-1:0] cnt_nxt;
    logic [SW-1:0] sample_nxt;
    logic          final_blk;
    logic          rd_en;
    logic [SW-1:0] rd_smp;
    logic [BW-1:0] rd_beat;
    logic          cmp_en;
    logic          err_clr;

    assign cnt_wrap   = (cnt == CNT_LAST);
    assign cnt_nxt    = cnt_wrap ? '0 : cnt + 1'b1;
    assign sample_nxt = (sample_idx == SMP_LAST) ? '0 : sample_idx + 1'b1;
    assign final_blk  = (sample_idx == SMP_LAST) && (epoch_idx == EP_LAST);

    // RAM has one clock of read latency, so each read targets the beat the
    // DNN consumes in the following clock: address uses next-clock cnt/sample.
    always_comb begin
        rd_en   = 1'b0;
        rd_smp  = sample_idx;
        rd_beat = cnt_nxt[BW-1:0];
        if (state == NETRST && rst_cnt == RST_LAST) begin
            rd_en   = 1'b1;
            rd_smp  = '0;
            rd_beat = '0;
        end else if (state == RUN && !(cnt_wrap && final_blk)) begin
            rd_en = (cnt_nxt < CNT_BEATS);
            if (cnt_wrap) begin
                rd_smp = sample_nxt;
            end
        end
        // Next clock is IDLE on abort, so the fetched data would be unused.
        if (abort) begin
            rd_en = 1'b0;
        end
    end

    assign mem_rd_en = rd_en;
    assign mem_addr  = rd_en ? {rd_smp, rd_beat} : '0;

    assign cmp_en  = (state == RUN || state == DRAIN) && (warm_blk == LAT_FULL)
                     && (cnt < CNT_OBEATS);
    assign err_clr = (state == IDLE) && start && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rst_cnt    <= '0;
            warm_blk   <= '0;
            drain_blk  <= '0;
            sample_idx <= '0;
            epoch_idx  <= '0;
            dnn_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                cnt       <= '0;
                dnn_reset <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= NETRST;
                            busy       <= 1'b1;
                            rst_cnt    <= '0;
                            sample_idx <= '0;
                            epoch_idx  <= '0;
                        end
                    end
                    NETRST: begin
                        if (rst_cnt == RST_LAST) begin
                            state     <= RUN;
                            dnn_reset <= 1'b0;
                            cnt       <= '0;
                            warm_blk  <= '0;
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        cnt <= cnt_nxt;
                        if (cnt_wrap) begin
                            sample_idx <= sample_nxt;
                            if (sample_idx == SMP_LAST) begin
                                epoch_idx <= epoch_idx + 1'b1;
                            end
                            if (warm_blk != LAT_FULL) begin
                                warm_blk <= warm_blk + 1'b1;
                            end
                            if (final_blk) begin
                                state     <= DRAIN;
                                drain_blk <= '0;
                            end
                        end
                    end
                    DRAIN: begin
                        cnt <= cnt_nxt;
                        if (cnt_wrap) begin
                            if (warm_blk != LAT_FULL) begin
                                warm_blk <= warm_blk + 1'b1;
                            end
                            if (drain_blk == LAT_LAST) begin
                                state     <= DONE;
                                dnn_reset <= 1'b1;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                drain_blk <= drain_blk + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    dnn_err_counter #(
        .ZO(ZO)
    ) u_err (
        .clk   (clk),
        .reset (reset),
        .clr   (err_clr),
        .en    (cmp_en),
        .a     (a_out),
        .b     (y_out),
        .count (err_count)
    );

endmodule

// File: tb/tb_dnn_train_sequencer.sv
module tb_dnn_train_sequencer;

    localparam int CPC = 6, BEATS = 4, OUT_BEATS = 4, NS = 4, NE = 2, LAT = 3, RST = 2;
    localparam int NT = NS * NE;
    localparam int BW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT
    logic        reset, start, abort;
    logic        dnn_reset, mem_rd_en, busy, done;
    logic [3:0]  mem_addr;
    logic [0:0]  a_out, y_out;
    logic [1:0]  epoch_idx;
    logic [15:0] err_count;

    // saturation DUT: 256 x 9 blocks of 4 beats x 8 mismatching bits = 73728 mismatches
    logic        s_reset, s_start, s_abort;
    logic        s_dnn_reset, s_rd_en, s_busy, s_done;
    logic [9:0]  s_addr;
    logic [7:0]  s_a, s_y;
    logic [3:0]  s_epoch;
    logic [15:0] s_err;
    assign s_a = 8'hFF;
    assign s_y = 8'h00;
    assign s_abort = 1'b0;

    dnn_train_sequencer #(
        .CPC(CPC), .BEATS(BEATS), .OUT_BEATS(OUT_BEATS), .ZO(1),
        .N_SAMPLES(NS), .N_EPOCHS(NE), .LAT_BLK(LAT), .RST_CLKS(RST)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .dnn_reset(dnn_reset), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .a_out(a_out), .y_out(y_out), .busy(busy), .done(done),
        .epoch_idx(epoch_idx), .err_count(err_count)
    );

    dnn_train_sequencer #(
        .CPC(6), .BEATS(4), .OUT_BEATS(4), .ZO(8),
        .N_SAMPLES(256), .N_EPOCHS(9), .LAT_BLK(3), .RST_CLKS(2)
    ) dut_sat (
        .clk(clk), .reset(s_reset), .start(s_start), .abort(s_abort),
        .dnn_reset(s_dnn_reset), .mem_rd_en(s_rd_en), .mem_addr(s_addr),
        .a_out(s_a), .y_out(s_y), .busy(s_busy), .done(s_done),
        .epoch_idx(s_epoch), .err_count(s_err)
    );

    // ---------------- reference model ----------------
    typedef struct {
        longint cyc;
        int     addr;
    } rd_t;

    rd_t    rq[$];
    longint dq[$];
    longint cyc = 0;
    longint c0 = -10, r = -10, endc = -10, ab = -10;
    int     exp_err = 0;
    int     checks = 0, errors = 0;
    int     mode = 0;
    bit     mon_on = 0;
    bit     sat_fin = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit exp_busy(input longint t);
        return t > c0 && t < endc && t <= ab;
    endfunction

    function automatic bit exp_dnn_reset(input longint t);
        return !(t >= r && t < endc && t <= ab);
    endfunction

    function automatic bit in_win(input longint t);
        return t >= r + LAT * CPC && t < endc && t <= ab && ((t - r) % CPC) < OUT_BEATS;
    endfunction

    // Epoch = completed sample blocks / N_SAMPLES; frozen at the abort clock.
    function automatic int exp_epoch(input longint t);
        longint tt, k;
        tt = (t < ab) ? t : ab;
        if (tt < r) return 0;
        k = (tt - r) / CPC;
        if (k > NT) k = NT;
        return int'(k / NS);
    endfunction

    task automatic start_run(input longint c);
        rd_t e;
        c0   = c;
        r    = c + 1 + RST;
        endc = r + (NT + LAT) * CPC;
        ab   = longint'(1) << 40;
        rq.delete();
        dq.delete();
        for (int s = 0; s < NT; s++) begin
            for (int b = 0; b < BEATS; b++) begin
                e.cyc  = r + s * CPC + b - 1;
                e.addr = ((s % NS) << BW) | b;
                rq.push_back(e);
            end
        end
        dq.push_back(endc);
    endtask

    task automatic model_idle();
        c0 = -10; r = -10; endc = -10; ab = -10;
        rq.delete();
        dq.delete();
        exp_err = 0;
    endtask

    // ---------------- monitor ----------------
    longint mt;
    bit     me;
    always @(negedge clk) begin
        if (mon_on) begin
            mt = cyc;
            if (mt == c0 + 1) exp_err = 0;
            chk("busy", busy, exp_busy(mt));
            chk("dnn_reset", dnn_reset, exp_dnn_reset(mt));
            chk("epoch_idx", epoch_idx, exp_epoch(mt));
            chk("err_count", err_count, exp_err);
            me = dq.size() > 0 && dq[0] == mt;
            chk("done", done, me);
            if (me) void'(dq.pop_front());
            me = rq.size() > 0 && rq[0].cyc == mt;
            chk("mem_rd_en", mem_rd_en, me);
            if (me && mem_rd_en) chk("mem_addr", mem_addr, rq[0].addr);
            if (me) void'(rq.pop_front());
            if (in_win(mt)) begin
                exp_err += $countones(a_out ^ y_out);
                if (exp_err > 65535) exp_err = 65535;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        longint t;
        bit mis;
        @(posedge clk);
        #1;
        t = cyc;
        start = (mode == 2 && t > c0 && t < endc && $urandom_range(0, 5) == 0);
        y_out = 1'($urandom_range(0, 1));
        case (mode)
            1:       mis = (t >= r && t < endc && (t - r) / CPC <= 3);
            2, 3:    mis = 1'($urandom_range(0, 1));
            default: mis = 1'b0;
        endcase
        a_out = y_out ^ mis;
    endtask

    task automatic do_start();
        longint c;
        tick();
        start = 1'b1;
        c = cyc;
        tick();
        start_run(c);
    endtask

    task automatic wait_end();
        while (cyc < endc + 2) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; a_out = '0; y_out = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_dnn_reset", dnn_reset, 1);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_epoch", epoch_idx, 0);
        chk("rst_err", err_count, 0);
        #20 reset = 1'b1;
        mon_on = 1'b1;
        repeat (3) tick();

        // Mismatch everywhere in blocks 0..3: only block 3 cnt 0..3 counts.
        mode = 1;
        do_start();
        wait_end();
        chk("runA_err_block3", err_count, 4);

        // Random data with stray start pulses while busy.
        mode = 2;
        do_start();
        wait_end();

        // Abort at cnt=2 of block 5.
        mode = 3;
        do_start();
        while (cyc < r + 5 * CPC + 2) tick();
        abort = 1'b1;
        ab = cyc;
        while (rq.size() > 0 && rq[$].cyc >= ab) void'(rq.pop_back());
        while (dq.size() > 0 && dq[$] >= ab) void'(dq.pop_back());
        tick();
        abort = 1'b0;
        chk("abort_dnn_reset", dnn_reset, 1);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_busy", busy, 0);
        repeat (5) tick();

        // start together with abort from IDLE must not launch.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) tick();
        chk("abort_start_idle", busy, 0);

        // Async reset in the middle of DRAIN.
        do_start();
        while (cyc < r + NT * CPC + CPC + 1) tick();
        #1 reset = 1'b0;
        model_idle();
        #1;
        chk("arst_dnn_reset", dnn_reset, 1);
        chk("arst_rd_en", mem_rd_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", err_count, 0);
        chk("arst_epoch", epoch_idx, 0);
        tick();
        tick();
        #6 reset = 1'b1;
        repeat (3) tick();

        // Clean random run after the reset.
        mode = 2;
        do_start();
        wait_end();

        for (int i = 0; i < 30000 && !sat_fin; i++) tick();
        chk("sat_finished", sat_fin, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        s_reset = 1'b1; s_start = 1'b0;
        #2 s_reset = 1'b0;
        #21 s_reset = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (s_done) break;
        end
        chk("sat_done", s_done, 1);
        chk("sat_err", s_err, 16'hFFFF);
        chk("sat_epoch", s_epoch, 9);
        sat_fin = 1'b1;
    end

endmodule
